sys_bridge: RTL and testbench

// CPU-side initiator of the device bus. Turns one CPU load/store into a

---
 rtl/bridge_defs.sv | 31 +++
 rtl/bridge_addr_dec.sv | 25 ++
 rtl/sys_bridge.sv | 121 ++++++++++++
 tb/tb_sys_bridge.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bridge_defs.sv
// Shared constants and types for the CPU-to-device bus bridge.
package bridge_defs;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_DEV  = 3;
    localparam int unsigned IRQ_W  = 3;
    localparam int unsigned HWINT_W = 6;
    localparam int unsigned OFS_W  = 2;

    localparam logic [ADDR_W-1:0] DEF_BASE0 = 32'h0000_7F00;
    localparam logic [ADDR_W-1:0] DEF_BASE1 = 32'h0000_7F10;
    localparam logic [ADDR_W-1:0] DEF_BASE2 = 32'h0000_7F20;

    localparam int unsigned DEV_TIMER0 = 0;
    localparam int unsigned DEV_TIMER1 = 1;
    localparam int unsigned DEV_SPARE2 = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Request fields that must survive the whole access.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
    } req_t;

endpackage

// File: rtl/bridge_addr_dec.sv
// Combinational address decoder: one-hot device hit plus misalignment/unmapped error.
module bridge_addr_dec
    import bridge_defs::*;
#(
    parameter logic [ADDR_W-1:0] BASE0 = DEF_BASE0,
    parameter logic [ADDR_W-1:0] BASE1 = DEF_BASE1,
    parameter logic [ADDR_W-1:0] BASE2 = DEF_BASE2
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [N_DEV-1:0]  hit_o,
    output logic              err_o
);

    logic ofs_ok_c;

    // Word offset 3 lies outside each device's register map.
    assign ofs_ok_c = (addr_i[3:2] != 2'b11);

    assign hit_o[DEV_TIMER0] = (addr_i[ADDR_W-1:4] == BASE0[ADDR_W-1:4]) && ofs_ok_c;
    assign hit_o[DEV_TIMER1] = (addr_i[ADDR_W-1:4] == BASE1[ADDR_W-1:4]) && ofs_ok_c;
    assign hit_o[DEV_SPARE2] = (addr_i[ADDR_W-1:4] == BASE2[ADDR_W-1:4]) && ofs_ok_c;

    assign err_o = (addr_i[1:0] != 2'b00) || (hit_o == '0);

endmodule

// File: rtl/sys_bridge.sv
// CPU-side device bus initiator: one registered single-word access per CPU request,
// plus a one-cycle IRQ register feeding the CPU HWInt vector.
module sys_bridge
    import bridge_defs::*;
#(
    parameter logic [ADDR_W-1:0] BASE0 = DEF_BASE0,
    parameter logic [ADDR_W-1:0] BASE1 = DEF_BASE1,
    parameter logic [ADDR_W-1:0] BASE2 = DEF_BASE2
) (
    input  logic                      clk,
    input  logic                      RST_I,
    input  logic                      PrReq,
    input  logic [ADDR_W-1:0]         PrAddr,
    input  logic                      PrWE,
    input  logic [DATA_W-1:0]         PrWD,
    output logic [DATA_W-1:0]         PrRD,
    output logic                      PrAck,
    output logic                      PrErr,
    output logic [HWINT_W-1:0]        HWInt,
    output logic [OFS_W-1:0]          ADD_O,
    output logic [N_DEV-1:0]          WE_O,
    output logic [DATA_W-1:0]         DAT_O,
    input  logic [N_DEV*DATA_W-1:0]   DAT_I,
    input  logic [IRQ_W-1:0]          IRQ_I
);

    state_e              state_q;
    req_t                req_q;
    logic [DATA_W-1:0]   rd_q;
    logic                ack_q;
    logic                err_q;
    logic [HWINT_W-1:0]  hwint_q;
    logic [OFS_W-1:0]    add_q;
    logic [N_DEV-1:0]    we_o_q;
    logic [DATA_W-1:0]   dat_q;

    logic [ADDR_W-1:0]   dec_addr_c;
    logic [N_DEV-1:0]    dec_hit_c;
    logic                dec_err_c;
    logic [DATA_W-1:0]   rd_slice_c;

    // Decode the incoming address while idle, the latched one during the access.
    assign dec_addr_c = (state_q == ST_IDLE) ? PrAddr : req_q.addr;

    bridge_addr_dec #(
        .BASE0 (BASE0),
        .BASE1 (BASE1),
        .BASE2 (BASE2)
    ) u_addr_dec (
        .addr_i (dec_addr_c),
        .hit_o  (dec_hit_c),
        .err_o  (dec_err_c)
    );

    // Read slice of the hit device; zero for stores and failed decodes.
    always_comb begin
        rd_slice_c = '0;
        if (!dec_err_c && !req_q.we) begin
            for (int unsigned k = 0; k < N_DEV; k++) begin
                if (dec_hit_c[k]) begin
                    rd_slice_c = rd_slice_c | DAT_I[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            rd_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            hwint_q <= '0;
            add_q   <= '0;
            we_o_q  <= '0;
            dat_q   <= '0;
        end else begin
            hwint_q <= {(HWINT_W-IRQ_W)'(0), IRQ_I};
            case (state_q)
                ST_IDLE: begin
                    if (PrReq) begin
                        req_q.addr <= PrAddr;
                        req_q.we   <= PrWE;
                        add_q      <= PrAddr[3:2];
                        dat_q      <= PrWD;
                        we_o_q     <= (PrWE && !dec_err_c) ? dec_hit_c : '0;
                        state_q    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rd_q    <= rd_slice_c;
                    err_q   <= dec_err_c;
                    ack_q   <= 1'b1;
                    we_o_q  <= '0;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    we_o_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign PrRD  = rd_q;
    assign PrAck = ack_q;
    assign PrErr = err_q;
    assign HWInt = hwint_q;
    assign ADD_O = add_q;
    assign WE_O  = we_o_q;
    assign DAT_O = dat_q;

endmodule

// File: tb/tb_sys_bridge.sv
// Directed self-checking bench for sys_bridge.
module tb_sys_bridge;

    logic         clk;
    logic         RST_I;
    logic         PrReq;
    logic [31:0]  PrAddr;
    logic         PrWE;
    logic [31:0]  PrWD;
    logic [31:0]  PrRD;
    logic         PrAck;
    logic         PrErr;
    logic [5:0]   HWInt;
    logic [1:0]   ADD_O;
    logic [2:0]   WE_O;
    logic [31:0]  DAT_O;
    logic [95:0]  DAT_I;
    logic [2:0]   IRQ_I;

    int n_checks = 0;
    int n_errors = 0;

    sys_bridge dut (
        .clk    (clk),
        .RST_I  (RST_I),
        .PrReq  (PrReq),
        .PrAddr (PrAddr),
        .PrWE   (PrWE),
        .PrWD   (PrWD),
        .PrRD   (PrRD),
        .PrAck  (PrAck),
        .PrErr  (PrErr),
        .HWInt  (HWInt),
        .ADD_O  (ADD_O),
        .WE_O   (WE_O),
        .DAT_O  (DAT_O),
        .DAT_I  (DAT_I),
        .IRQ_I  (IRQ_I)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Full access called at a negedge; scrambles the CPU inputs after acceptance.
    task automatic do_access(input string tag, input logic [31:0] addr, input logic we,
                             input logic [31:0] wd, input logic [2:0] exp_we,
                             input logic [1:0] exp_add, input logic exp_err,
                             input logic [31:0] exp_rd);
        PrReq  = 1'b1;
        PrAddr = addr;
        PrWE   = we;
        PrWD   = wd;
        @(posedge clk); @(negedge clk);
        check_eq({tag, ".we"},    32'(WE_O),  32'(exp_we));
        check_eq({tag, ".add"},   32'(ADD_O), 32'(exp_add));
        check_eq({tag, ".dat"},   DAT_O,      wd);
        check_eq({tag, ".noack"}, 32'(PrAck), 32'd0);
        PrAddr = addr ^ 32'h0000_0014;
        PrWE   = ~we;
        PrWD   = ~wd;
        @(posedge clk); @(negedge clk);
        check_eq({tag, ".ack"},   32'(PrAck), 32'd1);
        check_eq({tag, ".err"},   32'(PrErr), 32'(exp_err));
        check_eq({tag, ".rd"},    PrRD,       exp_rd);
        check_eq({tag, ".weclr"}, 32'(WE_O),  32'd0);
        PrReq = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq({tag, ".ackend"}, 32'(PrAck), 32'd0);
        check_eq({tag, ".errend"}, 32'(PrErr), 32'd0);
        check_eq({tag, ".weidle"}, 32'(WE_O),  32'd0);
    endtask

    initial begin
        RST_I  = 1'b1;
        PrReq  = 1'b0;
        PrAddr = '0;
        PrWE   = 1'b0;
        PrWD   = '0;
        IRQ_I  = 3'b000;
        DAT_I  = {32'h0000_2222, 32'h0000_0064, 32'hAAAA_0000};
        #1;
        check_eq("rst.rd",    PrRD,        32'd0);
        check_eq("rst.ack",   32'(PrAck),  32'd0);
        check_eq("rst.err",   32'(PrErr),  32'd0);
        check_eq("rst.hwint", 32'(HWInt),  32'd0);
        check_eq("rst.add",   32'(ADD_O),  32'd0);
        check_eq("rst.we",    32'(WE_O),   32'd0);
        check_eq("rst.dat",   DAT_O,       32'd0);
        @(negedge clk); @(negedge clk);
        RST_I = 1'b0;
        @(negedge clk);

        do_access("st_t0",    32'h0000_7F00, 1'b1, 32'h0000_0009, 3'b001, 2'd0, 1'b0, 32'd0);
        do_access("ld_t1",    32'h0000_7F14, 1'b0, 32'h1234_5678, 3'b000, 2'd1, 1'b0, 32'h0000_0064);
        do_access("ld_t0",    32'h0000_7F04, 1'b0, 32'h0,         3'b000, 2'd1, 1'b0, 32'hAAAA_0000);
        do_access("ld_mis",   32'h0000_7F02, 1'b0, 32'h0,         3'b000, 2'd0, 1'b1, 32'd0);
        do_access("st_mis",   32'h0000_7F12, 1'b1, 32'h55,        3'b000, 2'd0, 1'b1, 32'd0);
        do_access("st_unmap", 32'h0000_7F30, 1'b1, 32'h77,        3'b000, 2'd0, 1'b1, 32'd0);
        do_access("ld_ofs3",  32'h0000_7F1C, 1'b0, 32'h0,         3'b000, 2'd3, 1'b1, 32'd0);
        do_access("st_d2ro",  32'h0000_7F28, 1'b1, 32'hCAFE_F00D, 3'b100, 2'd2, 1'b0, 32'd0);
        do_access("ld_d2",    32'h0000_7F28, 1'b0, 32'h0,         3'b000, 2'd2, 1'b0, 32'h0000_2222);

        // IRQ registered with one-cycle latency, independent of a concurrent store.
        check_eq("irq.pre", 32'(HWInt), 32'd0);
        IRQ_I = 3'b010;
        check_eq("irq.notyet", 32'(HWInt), 32'd0);
        do_access("st_t1_irq", 32'h0000_7F10, 1'b1, 32'h0000_00A5, 3'b010, 2'd0, 1'b0, 32'd0);
        check_eq("irq.held", 32'(HWInt), 32'h02);
        IRQ_I = 3'b111;
        @(posedge clk); @(negedge clk);
        check_eq("irq.all", 32'(HWInt), 32'h07);

        // Reset asserted mid-ACCESS aborts the access with no ack.
        IRQ_I  = 3'b001;
        PrReq  = 1'b1;
        PrAddr = 32'h0000_7F00;
        PrWE   = 1'b1;
        PrWD   = 32'h0000_0033;
        @(posedge clk); @(negedge clk);
        check_eq("rstmid.pre_we",  32'(WE_O),  32'b001);
        check_eq("rstmid.pre_irq", 32'(HWInt), 32'h01);
        #2 RST_I = 1'b1;
        #1;
        check_eq("rstmid.we",    32'(WE_O),  32'd0);
        check_eq("rstmid.ack",   32'(PrAck), 32'd0);
        check_eq("rstmid.hwint", 32'(HWInt), 32'd0);
        check_eq("rstmid.dat",   DAT_O,      32'd0);
        PrReq = 1'b0;
        IRQ_I = 3'b000;
        @(negedge clk);
        RST_I = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq("rstmid.noack", 32'(PrAck), 32'd0);
        @(posedge clk); @(negedge clk);
        check_eq("rstmid.noack2", 32'(PrAck), 32'd0);
        do_access("post_rst", 32'h0000_7F14, 1'b0, 32'h0, 3'b000, 2'd1, 1'b0, 32'h0000_0064);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
